// File: rtl/axis_tx_arbiter.sv
// Packet-level round-robin arbiter: shares one AXI-Stream TX channel among NUM_REQ requesters.
// A grant is held from the first beat until the granted requester's tlast beat is accepted.
module axis_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int TID_WIDTH   = 8,
  parameter int CNT_WIDTH   = 16,
  localparam int GW         = $clog2(NUM_REQ)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*TDATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           tready,
  output logic                           tvalid,
  output logic [TDATA_WIDTH-1:0]         tdata,
  output logic                           tlast,
  output logic [TID_WIDTH-1:0]           tid,
  output logic                           busy,
  output logic [GW-1:0]                  grant_id,
  output logic [CNT_WIDTH-1:0]           pkt_count
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                   state, state_nxt;
  logic [GW-1:0]            ptr;
  logic [GW-1:0]            pick;
  logic                     found;
  logic [GW:0]              idx;
  logic                     pkt_done;
  logic [TDATA_WIDTH-1:0]   lane_data [NUM_REQ];

  // Per-lane data slice and ready steering
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_data[i] = req_data[i*TDATA_WIDTH +: TDATA_WIDTH];
    assign req_ready[i] = (state == XFER) && (grant_id == GW'(i)) && tready;
  end

  // Round-robin search starting just above the last completed grant, wrapping at NUM_REQ
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
      if (!found && req_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  assign pkt_done = (state == XFER) && tvalid && tready && tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)    state_nxt = XFER;
      XFER:    if (pkt_done) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == XFER);
    tvalid = 1'b0;
    tdata  = '0;
    tlast  = 1'b0;
    tid    = '0;
    if (state == XFER) begin
      tvalid = req_valid[grant_id];
      tdata  = lane_data[grant_id];
      tlast  = req_last[grant_id];
      tid    = TID_WIDTH'(grant_id);
    end
  end

  // Reset ptr to the top index so requester 0 wins the first arbitration
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr       <= GW'(NUM_REQ-1);
      grant_id  <= '0;
      pkt_count <= '0;
    end else begin
      if (state == IDLE && found) grant_id <= pick;
      if (pkt_done) begin
        ptr       <= grant_id;
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Randomized scoreboard bench for axis_tx_arbiter: per-requester expected-beat queues
// plus a packet-level round-robin model that predicts grants, busy and packet count.
module tb_axis_tx_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TW  = 8;
  localparam int CW  = 8;
  localparam int GW  = $clog2(N);

  logic              aclk, aresetn;
  logic [N-1:0]      req_valid, req_last, req_ready;
  logic [N*W-1:0]    req_data;
  logic              tready, tvalid, tlast, busy;
  logic [W-1:0]      tdata;
  logic [TW-1:0]     tid;
  logic [GW-1:0]     grant_id;
  logic [CW-1:0]     pkt_count;

  axis_tx_arbiter #(.NUM_REQ(N), .TDATA_WIDTH(W), .TID_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tready(tready), .tvalid(tvalid),
    .tdata(tdata), .tlast(tlast), .tid(tid), .busy(busy), .grant_id(grant_id),
    .pkt_count(pkt_count)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t stim_q [N][$];
  beat_t exp_q  [N][$];
  int    gl [$];
  int    bcnt [N];

  int checks = 0, failures = 0;
  int tr_mode = 0, bub_en = 0, tcnt = 0;
  logic [N-1:0] acc = '0;

  // packet-level model state
  bit            m_busy = 0;
  int            m_g = 0, m_ptr = N-1, m_gid = 0;
  logic [CW-1:0] m_cnt = '0;
  bit            prev_hold = 0;
  logic [W-1:0]  prev_data = '0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic push_pkt(input int r, input int nb, input logic [W-1:0] base, input bit rnd);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.data = rnd ? W'($urandom) : base + W'(k);
      b.last = (k == nb - 1);
      stim_q[r].push_back(b);
      exp_q[r].push_back(b);
    end
  endtask

  task automatic rst_chk();
    chk("rst_tvalid", 64'(tvalid), 0);
    chk("rst_tlast", 64'(tlast), 0);
    chk("rst_tdata", 64'(tdata), 0);
    chk("rst_tid", 64'(tid), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_grant_id", 64'(grant_id), 0);
    chk("rst_pkt_count", 64'(pkt_count), 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      stim_q[i].delete();
      exp_q[i].delete();
      bcnt[i] = 0;
    end
    gl.delete();
    m_busy = 0; m_ptr = N-1; m_gid = 0; m_cnt = '0; prev_hold = 0;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge aclk);
      done = !m_busy;
      for (int i = 0; i < N; i++) if (stim_q[i].size() != 0) done = 0;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain actual=pending required=empty t=%0t", $time);
    end
  endtask

  // Requester driver: each lane presents the head of its beat queue
  initial begin
    req_valid = '0; req_data = '0; req_last = '0; tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      tcnt++;
      case (tr_mode)
        0:       tready = 1'b1;
        1:       tready = (tcnt % 3 == 0);
        default: tready = ($urandom_range(3) != 0);
      endcase
      for (int i = 0; i < N; i++) begin
        if (!aresetn) begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end else begin
          if (acc[i] && stim_q[i].size() != 0) void'(stim_q[i].pop_front());
          if (stim_q[i].size() != 0 && !(bub_en != 0 && $urandom_range(3) == 0)) begin
            req_valid[i]           = 1'b1;
            req_data[i*W +: W]     = stim_q[i][0].data;
            req_last[i]            = stim_q[i][0].last;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: checks what will happen at the next rising edge, then advances the model
  initial begin
    logic [N-1:0] er;
    beat_t e;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        acc = '0;
      end else begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("pkt_count", 64'(pkt_count), 64'(m_cnt));
        if (!m_busy) begin
          chk("idle_tvalid", 64'(tvalid), 0);
          chk("idle_tlast", 64'(tlast), 0);
          chk("idle_tdata", 64'(tdata), 0);
          chk("idle_tid", 64'(tid), 0);
          chk("idle_req_ready", 64'(req_ready), 0);
          acc = '0;
          prev_hold = 0;
          if (req_valid != '0) begin
            m_g = rr_pick(m_ptr, req_valid);
            m_gid = m_g;
            m_busy = 1;
          end
        end else begin
          er = '0;
          if (tready) er[m_g] = 1'b1;
          chk("tid", 64'(tid), 64'(m_g));
          chk("tvalid", 64'(tvalid), 64'(req_valid[m_g]));
          chk("req_ready", 64'(req_ready), 64'(er));
          if (tvalid && prev_hold) chk("tdata_hold", 64'(tdata), 64'(prev_data));
          prev_hold = tvalid && !tready;
          prev_data = tdata;
          acc = req_valid & req_ready;
          if (tvalid && tready) begin
            bcnt[m_g]++;
            checks++;
            if (exp_q[m_g].size() == 0) begin
              failures++;
              $display("FAIL extra_beat actual=tid%0d required=none t=%0t", m_g, $time);
            end else begin
              e = exp_q[m_g].pop_front();
              chk("tdata", 64'(tdata), 64'(e.data));
              chk("tlast", 64'(tlast), 64'(e.last));
            end
            if (tlast) begin
              gl.push_back(int'(tid));
              m_busy = 0;
              m_ptr = m_g;
              m_cnt = m_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    aresetn = 1'b1;
    #2 aresetn = 1'b0;
    #1 rst_chk();
    @(posedge aclk); #3 aresetn = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      chk("quiet_tvalid", 64'(tvalid), 0);
      chk("quiet_busy", 64'(busy), 0);
    end

    // round-robin: every requester holds two single-beat packets
    gl.delete();
    for (int r = 0; r < N; r++) push_pkt(r, 1, W'(32'h100 * r), 0);
    for (int r = 0; r < N; r++) push_pkt(r, 1, W'(32'h100 * r + 1), 0);
    repeat (17) @(posedge aclk);
    #1 chk("rr_count", 64'(pkt_count), 8);
    wait_drain(100);
    for (int k = 0; k < 8; k++) chk("rr_order", 64'(k < gl.size() ? gl[k] : -1), 64'(k % N));

    // single 3-beat packet from requester 2
    gl.delete();
    push_pkt(2, 3, W'(32'hA), 0);
    wait_drain(100);
    chk("single_tid", 64'(gl.size() > 0 ? gl[0] : -1), 2);
    chk("single_count", 64'(pkt_count), 9);

    // grant lock: requester 1 owns the channel while 0 and 2 queue up
    gl.delete();
    push_pkt(1, 4, W'(32'h1000), 0);
    repeat (3) @(posedge aclk);
    push_pkt(0, 1, W'(32'h2000), 0);
    push_pkt(2, 1, W'(32'h3000), 0);
    wait_drain(100);
    chk("lock_g0", 64'(gl.size() > 0 ? gl[0] : -1), 1);
    chk("lock_g1", 64'(gl.size() > 1 ? gl[1] : -1), 2);
    chk("lock_g2", 64'(gl.size() > 2 ? gl[2] : -1), 0);

    // backpressure with tready 1,0,0 pattern and valid bubbles
    tr_mode = 1; bub_en = 1;
    for (int p = 0; p < 40; p++) push_pkt($urandom_range(N-1), $urandom_range(1, 5), '0, 1);
    wait_drain(5000);

    // fully random traffic
    tr_mode = 2;
    for (int p = 0; p < 150; p++) push_pkt($urandom_range(N-1), $urandom_range(1, 4), '0, 1);
    wait_drain(10000);

    // reset in the middle of a 5-beat packet from requester 3
    tr_mode = 0; bub_en = 0;
    for (int i = 0; i < N; i++) bcnt[i] = 0;
    push_pkt(3, 5, W'(32'h5000), 0);
    for (int c = 0; c < 100 && bcnt[3] < 2; c++) @(posedge aclk);
    #3 aresetn = 1'b0;
    model_reset();
    #1 rst_chk();
    @(posedge aclk); #3 aresetn = 1'b1;
    push_pkt(3, 1, W'(32'h6003), 0);
    push_pkt(1, 1, W'(32'h6001), 0);
    push_pkt(0, 1, W'(32'h6000), 0);
    wait_drain(100);
    chk("post_rst_g0", 64'(gl.size() > 0 ? gl[0] : -1), 0);
    chk("post_rst_g1", 64'(gl.size() > 1 ? gl[1] : -1), 1);
    chk("post_rst_g2", 64'(gl.size() > 2 ? gl[2] : -1), 3);

    // counter wrap: 3 + 253 = 256 packets since reset
    for (int p = 0; p < 253; p++) push_pkt(1, 1, W'(p), 0);
    wait_drain(2000);
    @(negedge aclk);
    chk("wrap_count", 64'(pkt_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
